tile_shuffler: RTL and testbench
================================

# tile_shuffler

Synthesizable source of the board's random tile arrangement: on a start pulse, a hardware Fisher-Yates shuffle builds a random permutation of the 24 edge (track) tiles and the 12 center (octagon) tiles. It sits directly upstream of board setup and replaces the non-synthesizable `$urandom` table lookup. The packed order buses have the same format board setup already consumes. Entropy comes from a free-running LFSR, so the result depends on the cycle at which the player presses start.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request for a new shuffle; honoured only in IDLE.
- `busy`  out  1  high while a shuffle is in progress.
- `done`  out  1  one-cycle pulse when the new orders are valid.
- `valid`  out  1  sticky; high once any shuffle has completed since reset.
- `random_edge_order`  out  96  slot k (0..23) at bits [4k+3:4k]; picture id 0..11.
- `random_center_order`  out  48  slot k (0..11) at bits [4k+3:4k]; picture id 0..11.

## Operation
- **LFSR**
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Loads `SEED` on reset and advances every cycle regardless of state.
- **Working arrays**
  - `e[0..23]` and `c[0..11]`, each entry 4 bits.
  - These are internal; the output registers are separate.
- **States**
  - **IDLE**: `start` moves to INIT.
  - **INIT**: load `e[k]=k>>1` (each picture appears twice) and `c[k]=k`. Set i=23. Go to SHUF_E.
  - **SHUF_E**: compute j = (lfsr * (i+1)) >> 16, which lies in 0..i. Swap e[i] and e[j]. If i==1, set i=11 and go to SHUF_C; otherwise decrement i.
  - **SHUF_C**: same rule applied to `c`. When i==1, go to DONE.
  - **DONE**: copy the arrays to the output buses, pulse `done`, set `valid`, and return to IDLE.
- **Arithmetic**
  - The product is 16 × 5 → 21 bits; j is bits [20:16], so j ≤ i by construction.
  - i==j is a legal no-op swap.
- **Output holding**
  - The outputs hold the previous arrangement throughout a shuffle.
  - They change only at the DONE edge.
- **Invariants**
  - Edge output: every picture id 0..11 appears exactly twice.
  - Center output: a permutation of 0..11.
- **Boundary conditions**
  - `start` while busy, or in the DONE cycle: ignored, not queued.
  - `start` held high: a new shuffle begins on each return to IDLE.
  - `rst` mid-shuffle: abort and return to IDLE. All outputs take their reset values and the LFSR reloads `SEED`.

## Timing
- **Reset values**
  - `busy`=0, `done`=0, `valid`=0.
  - `random_edge_order`=96'h0, `random_center_order`=48'h0.
  - State = IDLE, LFSR = `SEED`.
- **Latency** (`start` sampled high in IDLE at edge 0):
  - INIT during cycle 1.
  - SHUF_E during cycles 2–24 (23 swaps).
  - SHUF_C during cycles 25–35 (11 swaps).
  - DONE during cycle 36: the outputs update at the end-of-cycle-36 edge, `done` is high for that cycle, and `valid` is high from then on.
- `busy` is high in cycles 1–35 (INIT, SHUF_E, SHUF_C), low in DONE and IDLE.
- The next accepted `start` is sampled no earlier than cycle 37.
- One swap per cycle, using the LFSR value current in that cycle.
- Fully deterministic given `SEED` and the start cycle.

## Structure
- Shared package `chicken_pkg`:
  - `EDGE_N=24`, `CENTER_N=12`, `TILE_W=4`, `PIC_N=12`.
  - The packed-order slot layout.
  - A state enum shared with board setup.
- Sub-module `lfsr16` (parameter `SEED`; ports `clk`, `rst`, `q[15:0]`), reused by later dice logic.
- Swap logic: one read-modify-write of two array entries per cycle using a combinational index mux. No RAM.

## Test plan
- **Reset:** assert `rst` 3 cycles → all outputs 0, `busy`=0, `valid`=0; LFSR `q`=16'hACE1 in the first cycle after release.
- **Single shuffle:** `start` 5 cycles after reset release →
  - `busy` high for exactly 35 cycles and `done` high in cycle 36.
  - Edge histogram has each of 0..11 twice; center is a permutation of 0..11.
  - Result equals the golden model for `SEED`=16'hACE1.
- **Ignored start:** pulse `start` at cycles 10 and 36 of a shuffle → no second shuffle begins; `done` pulses once; outputs unchanged after cycle 36.
- **Reset mid-shuffle:** assert `rst` at cycle 12 → outputs 0, `valid`=0, state IDLE. A subsequent `start` gives the golden result for that new start cycle.
- **Back-to-back:** `start` held high for 100 cycles →
  - `done` pulses at cycles 36 and 73.
  - The second arrangement differs from the first.
  - Outputs stay stable between the two `done` pulses.
- **Seed sensitivity:** `SEED`=16'h0001, start at cycles 5 vs 6 → different arrangements, both passing the invariants.

Source files
------------

// File: rtl/chicken_pkg.sv
// Shared board constants, packed tile-order layout and the shuffle state encoding.
package chicken_pkg;

  localparam int unsigned EDGE_N       = 24;
  localparam int unsigned CENTER_N     = 12;
  localparam int unsigned TILE_W       = 4;
  localparam int unsigned PIC_N        = 12;
  localparam int unsigned LFSR_W       = 16;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned CIDX_W       = 4;
  localparam int unsigned PROD_W       = LFSR_W + IDX_W;
  localparam int unsigned EDGE_BUS_W   = EDGE_N * TILE_W;
  localparam int unsigned CENTER_BUS_W = CENTER_N * TILE_W;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  // Slot k of an order bus lives at bits [TILE_W*k +: TILE_W].
  typedef logic [TILE_W-1:0]       tile_t;
  typedef tile_t [EDGE_N-1:0]      edge_order_t;
  typedef tile_t [CENTER_N-1:0]    center_order_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SHUF_E = 3'd2,
    ST_SHUF_C = 3'd3,
    ST_DONE   = 3'd4
  } shuf_state_t;

  // Edge deck starts with every picture id twice, in pairs.
  function automatic tile_t edge_init(input int unsigned k);
    return TILE_W'(k / 2);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), reloads SEED on reset.
module lfsr16
  import chicken_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (q[0]) begin
      q <= (q >> 1) ^ LFSR_MASK;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/tile_shuffler.sv
// Fisher-Yates shuffle of the 24 edge and 12 center tiles, one swap per cycle,
// driven by a free-running LFSR so the result depends on when start is pressed.
module tile_shuffler
  import chicken_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [EDGE_BUS_W-1:0]   random_edge_order,
  output logic [CENTER_BUS_W-1:0] random_center_order
);

  shuf_state_t         r_state;
  shuf_state_t         w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [LFSR_W-1:0]   w_lfsr;
  logic [IDX_W-1:0]    w_j;
  logic                w_load;
  logic                w_swap_e;
  logic                w_swap_c;
  logic                w_publish;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  edge_order_t         r_e;
  center_order_t       r_c;
  edge_order_t         r_edge_out;
  center_order_t       r_center_out;
  logic                r_busy;
  logic                r_done;
  logic                r_valid;

  tile_t               w_e_i;
  tile_t               w_e_j;
  tile_t               w_c_i;
  tile_t               w_c_j;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // j = floor(lfsr * (i+1) / 2^16) always lands in 0..i.
  assign w_j = IDX_W'((PROD_W'(w_lfsr) * PROD_W'(r_idx + IDX_W'(1))) >> 16);

  assign w_e_i = r_e[r_idx];
  assign w_e_j = r_e[w_j];
  assign w_c_i = r_c[CIDX_W'(r_idx)];
  assign w_c_j = r_c[CIDX_W'(w_j)];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_swap_e    = 1'b0;
    w_swap_c    = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        w_load      = 1'b1;
        w_idx_nxt   = IDX_W'(EDGE_N - 1);
        w_state_nxt = ST_SHUF_E;
      end
      ST_SHUF_E: begin
        w_swap_e = 1'b1;
        if (r_idx == IDX_W'(1)) begin
          w_idx_nxt   = IDX_W'(CENTER_N - 1);
          w_state_nxt = ST_SHUF_C;
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      ST_SHUF_C: begin
        w_swap_c = 1'b1;
        if (r_idx == IDX_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_publish   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == ST_INIT) || (w_state_nxt == ST_SHUF_E) ||
                 (w_state_nxt == ST_SHUF_C);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Working arrays, output holding registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_e          <= '0;
      r_c          <= '0;
      r_edge_out   <= '0;
      r_center_out <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_load) begin
        for (int unsigned k = 0; k < EDGE_N; k++) r_e[k] <= edge_init(k);
        for (int unsigned k = 0; k < CENTER_N; k++) r_c[k] <= TILE_W'(k);
      end
      if (w_swap_e) begin
        r_e[r_idx] <= w_e_j;
        r_e[w_j]   <= w_e_i;
      end
      if (w_swap_c) begin
        r_c[CIDX_W'(r_idx)] <= w_c_j;
        r_c[CIDX_W'(w_j)]   <= w_c_i;
      end
      if (w_publish) begin
        r_edge_out   <= r_e;
        r_center_out <= r_c;
        r_valid      <= 1'b1;
      end
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign valid               = r_valid;
  assign random_edge_order   = r_edge_out;
  assign random_center_order = r_center_out;

endmodule

// File: tb/tb_tile_shuffler.sv
// Directed bench for tile_shuffler: handshake timing table, golden shuffle model,
// ignored/held start, mid-shuffle reset and seed sensitivity.
module tb_tile_shuffler;
  import chicken_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0;
  logic        busy, done, valid;
  logic [95:0] eo;
  logic [47:0] co;
  logic        rst2 = 1'b1, start2 = 1'b0;
  logic        busy2, done2, valid2;
  logic [95:0] eo2;
  logic [47:0] co2;
  logic [15:0] m1, m2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  tile_shuffler #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .valid(valid),
    .random_edge_order(eo), .random_center_order(co));

  tile_shuffler #(.SEED(16'h0001)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2), .valid(valid2),
    .random_edge_order(eo2), .random_center_order(co2));

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference LFSRs: value seen during the current cycle.
  always @(posedge clk) begin
    m1 <= rst  ? 16'hACE1 : lfsr_next(m1);
    m2 <= rst2 ? 16'h0001 : lfsr_next(m2);
  end

  // l0 is the LFSR value in the cycle start is sampled; swaps begin two cycles later.
  function automatic void golden(input logic [15:0] l0, output logic [95:0] ge,
                                 output logic [47:0] gc);
    int e[24];
    int c[12];
    logic [15:0] l;
    int j, t;
    for (int k = 0; k < 24; k++) e[k] = k / 2;
    for (int k = 0; k < 12; k++) c[k] = k;
    l = lfsr_next(l0);
    for (int i = 23; i >= 1; i--) begin
      l = lfsr_next(l);
      j = int'((32'(l) * 32'(i + 1)) >> 16);
      t = e[i]; e[i] = e[j]; e[j] = t;
    end
    for (int i = 11; i >= 1; i--) begin
      l = lfsr_next(l);
      j = int'((32'(l) * 32'(i + 1)) >> 16);
      t = c[i]; c[i] = c[j]; c[j] = t;
    end
    ge = '0;
    gc = '0;
    for (int k = 0; k < 24; k++) ge[4*k +: 4] = 4'(e[k]);
    for (int k = 0; k < 12; k++) gc[4*k +: 4] = 4'(c[k]);
  endfunction

  function automatic logic inv_ok(input logic [95:0] e, input logic [47:0] c);
    int he[16];
    int hc[16];
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < 16; p++) begin he[p] = 0; hc[p] = 0; end
    for (int k = 0; k < 24; k++) he[e[4*k +: 4]]++;
    for (int k = 0; k < 12; k++) hc[c[4*k +: 4]]++;
    for (int p = 0; p < 12; p++) if (he[p] != 2 || hc[p] != 1) ok = 1'b0;
    return ok;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int   cyc;
    logic busy;
    logic done;
    logic valid;
  } vec_t;

  vec_t        tbl[9];
  logic [15:0] l0, l0b;
  logic [95:0] ge1, ge2, ge3, ge4, ge5, gea, geb, ea, eb, e5;
  logic [47:0] gc1, gc2, gc3, gc4, gc5, gca, gcb, ca, cb, c5;
  int          busy_cnt, done_cnt, done_at, d1, d2, bad, busy_late;

  initial begin
    tbl[0] = '{0,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{1,  1'b1, 1'b0, 1'b0};
    tbl[2] = '{2,  1'b1, 1'b0, 1'b0};
    tbl[3] = '{24, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{25, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{35, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{36, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{37, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{40, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy",   96'(busy),  96'(0));
    chk("rst_done",   96'(done),  96'(0));
    chk("rst_valid",  96'(valid), 96'(0));
    chk("rst_edge",   eo,         96'(0));
    chk("rst_center", 96'(co),    96'(0));
    chk("rst_lfsr",   96'(dut.u_lfsr.q), 96'(16'hACE1));

    // Single shuffle, timing table
    repeat (5) tick();
    start = 1'b1;
    l0 = m1;
    golden(l0, ge1, gc1);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc > 0) tick();
      if (cyc == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = cyc; end
      if (cyc == 20) chk("hold_reset_value", eo, 96'(0));
      for (int t = 0; t < 9; t++) begin
        if (tbl[t].cyc == cyc) begin
          chk($sformatf("c%0d_busy", cyc),  96'(busy),  96'(tbl[t].busy));
          chk($sformatf("c%0d_done", cyc),  96'(done),  96'(tbl[t].done));
          chk($sformatf("c%0d_valid", cyc), 96'(valid), 96'(tbl[t].valid));
        end
      end
    end
    chk("s1_busy_cycles", 96'(busy_cnt), 96'(35));
    chk("s1_done_count",  96'(done_cnt), 96'(1));
    chk("s1_done_cycle",  96'(done_at),  96'(36));
    chk("s1_edge",        eo,            ge1);
    chk("s1_center",      96'(co),       96'(gc1));
    chk("s1_invariants",  96'(inv_ok(eo, co)), 96'(1));

    // Start pulses at cycles 10 and 36 of a shuffle are ignored
    repeat (3) tick();
    start = 1'b1;
    l0 = m1;
    golden(l0, ge2, gc2);
    done_cnt = 0; done_at = -1; bad = 0; busy_late = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      start = (cyc == 10) || (cyc == 36);
      if (done) begin done_cnt++; done_at = cyc; end
      if (cyc == 20) chk("ign_hold_prev", eo, ge1);
      if (cyc >= 37) begin
        if (busy) busy_late++;
        if (eo !== ge2 || co !== gc2) bad++;
      end
    end
    chk("ign_done_count", 96'(done_cnt),  96'(1));
    chk("ign_done_cycle", 96'(done_at),   96'(36));
    chk("ign_no_restart", 96'(busy_late), 96'(0));
    chk("ign_stable",     96'(bad),       96'(0));
    chk("ign_edge",       eo,             ge2);
    chk("ign_center",     96'(co),        96'(gc2));

    // Reset at cycle 12 aborts the shuffle
    repeat (2) tick();
    start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_edge",   eo,         96'(0));
    chk("rmid_center", 96'(co),    96'(0));
    chk("rmid_valid",  96'(valid), 96'(0));
    chk("rmid_busy",   96'(busy),  96'(0));
    chk("rmid_state",  96'(dut.r_state), 96'(ST_IDLE));
    repeat (4) tick();
    start = 1'b1;
    l0 = m1;
    golden(l0, ge3, gc3);
    for (int cyc = 1; cyc <= 37; cyc++) begin
      tick();
      start = 1'b0;
    end
    chk("rmid_after_edge",   eo,         ge3);
    chk("rmid_after_center", 96'(co),    96'(gc3));
    chk("rmid_after_valid",  96'(valid), 96'(1));

    // Start held high: back-to-back shuffles
    repeat (2) tick();
    start = 1'b1;
    l0 = m1;
    l0b = '0;
    golden(l0, ge4, gc4);
    done_cnt = 0; d1 = -1; d2 = -1; bad = 0;
    e5 = '0; c5 = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      if (cyc == 100) start = 1'b0;
      if (cyc == 37) l0b = m1;
      if (done) begin
        done_cnt++;
        if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
      end
      if (cyc == 37) chk("b2b_first_edge", eo, ge4);
      if (cyc > 37 && cyc <= 73 && (eo !== ge4 || co !== gc4)) bad++;
      if (cyc == 74) begin e5 = eo; c5 = co; end
    end
    golden(l0b, ge5, gc5);
    chk("b2b_done_count",  96'(done_cnt), 96'(2));
    chk("b2b_done1",       96'(d1),       96'(36));
    chk("b2b_done2",       96'(d2),       96'(73));
    chk("b2b_stable",      96'(bad),      96'(0));
    chk("b2b_second_edge", e5,            ge5);
    chk("b2b_second_ctr",  96'(c5),       96'(gc5));
    chk("b2b_differs",     96'({e5, c5} != {ge4, gc4}), 96'(1));
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Seed 16'h0001, start at cycle 5 vs 6 after reset release
    rst2 = 1'b1;
    repeat (3) tick();
    rst2 = 1'b0;
    repeat (5) tick();
    start2 = 1'b1;
    l0 = m2;
    golden(l0, gea, gca);
    tick();
    start2 = 1'b0;
    repeat (36) tick();
    ea = eo2; ca = co2;
    chk("seed_a_edge",   ea,      gea);
    chk("seed_a_center", 96'(ca), 96'(gca));
    chk("seed_a_inv",    96'(inv_ok(ea, ca)), 96'(1));
    rst2 = 1'b1;
    repeat (3) tick();
    rst2 = 1'b0;
    repeat (6) tick();
    start2 = 1'b1;
    l0 = m2;
    golden(l0, geb, gcb);
    tick();
    start2 = 1'b0;
    repeat (36) tick();
    eb = eo2; cb = co2;
    chk("seed_b_edge",   eb,      geb);
    chk("seed_b_center", 96'(cb), 96'(gcb));
    chk("seed_b_inv",    96'(inv_ok(eb, cb)), 96'(1));
    chk("seed_differs",  96'({ea, ca} != {eb, cb}), 96'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
